// File: rtl/layer_output_dispatcher.sv
// -----------------------------------------------------------------------------
// layer_output_dispatcher
//
// Transmit side of the inter-layer ack protocol. When the MAC stage pulses
// start, all NUM_OUT results on data_in are captured in parallel. They are
// then replayed one word per beat, in index order, whenever ready is high.
// Every transferred word comes with a one-cycle ack pulse. done pulses once
// after the last ack of a pass. All flops update on the falling edge of clk.
//
// Optional build macro: LAYER_DISPATCH_GAP_EN
//   When this macro is defined, a one-cycle GAP state is inserted after every
//   ack except the last one. ack is therefore never high on two consecutive
//   cycles.
//
// Ports:
//   clk        clock (falling-edge active)
//   rst        asynchronous active-low reset
//   start      one-cycle pulse; data_in valid in the same cycle
//   data_in    packed results, element k at [k*DATA_W +: DATA_W]
//   ready      downstream can take a beat this cycle
//   out_data   current result word (registered)
//   out_idx    index of out_data (registered)
//   ack        one-cycle pulse per transferred word
//   busy       high while a pass is in flight
//   done       one-cycle pulse after the final ack of a pass
//   start_err  sticky flag: start seen while not idle
// -----------------------------------------------------------------------------
module layer_output_dispatcher #(
  parameter int NUM_OUT = 2,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_OUT*DATA_W-1:0] data_in,
  input  logic                      ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      ack,
  output logic                      busy,
  output logic                      done,
  output logic                      start_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [NUM_OUT-1:0][DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]                out_data_q, out_data_d;
  logic [IDX_W-1:0]                 out_idx_q, out_idx_d;
  logic                             ack_q, ack_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             err_q, err_d;

  logic [DATA_W-1:0]                cur_word;
  logic                             last_idx;

  // The word selection is written as a compare-mux over the elements. This
  // keeps it valid when IDX_W is wider than the minimum needed for NUM_OUT.
  always_comb begin
    cur_word = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (idx_q == IDX_W'(k)) cur_word = hold_q[k];
    end
  end

  assign last_idx = (idx_q == IDX_W'(NUM_OUT - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    ack_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;

    // A start that arrives in any state other than IDLE is dropped and is
    // recorded. This includes the DONE cycle.
    if (start && (state_q != ST_IDLE)) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hold_d  = data_in;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ready) begin
          out_data_d = cur_word;
          out_idx_d  = idx_q;
          ack_d      = 1'b1;
          if (last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
`ifdef LAYER_DISPATCH_GAP_EN
            state_d = ST_GAP;
`endif
          end
        end
      end
      // This state is only reachable when the gap build is enabled. It
      // ignores ready for exactly one cycle.
      ST_GAP: begin
        state_d = ST_SEND;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign start_err = err_q;

endmodule

// File: tb/tb_layer_output_dispatcher.sv
// -----------------------------------------------------------------------------
// Testbench for layer_output_dispatcher.
//
// The DUT updates on the falling edge of clk. The bench drives inputs and
// samples outputs on the rising edge. A pass-level reference model tracks the
// following items:
//   - the queue of words still to be sent
//   - whether a pass is active
//   - the pending done pulse
//   - the pending gap cycle, in the gap build
// -----------------------------------------------------------------------------
module tb_layer_output_dispatcher;

  localparam int NUM_OUT = 2;
  localparam int DATA_W  = 16;
  localparam int IDX_W   = 1;
  localparam int DW      = NUM_OUT * DATA_W;
`ifdef LAYER_DISPATCH_GAP_EN
  localparam bit GAP     = 1'b1;
`else
  localparam bit GAP     = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DW-1:0]     data_in = '0;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              ack, busy, done, start_err;

  int checks = 0;
  int errors = 0;

  layer_output_dispatcher #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .ready(ready),
    .out_data(out_data), .out_idx(out_idx), .ack(ack), .busy(busy),
    .done(done), .start_err(start_err)
  );

  always #5 clk = ~clk;

  // Reference model state and expected outputs.
  logic [DATA_W-1:0] q_data[$];
  int                q_idx[$];
  bit                m_active, m_finish, m_gap;
  logic [DATA_W-1:0] e_data;
  logic [31:0]       e_idx;
  bit                e_ack, e_busy, e_done, e_err;
  int                n_ack_seen;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_data.delete(); q_idx.delete();
    m_active = 0; m_finish = 0; m_gap = 0;
    e_data = '0; e_idx = '0; e_ack = 0; e_busy = 0; e_done = 0; e_err = 0;
  endtask

  // Predicts the outputs that follow the next falling edge, given these inputs.
  task automatic model_step(input bit st, input bit rdy, input logic [DW-1:0] d);
    e_ack  = 0;
    e_done = 0;
    if (!m_active) begin
      if (st) begin
        for (int k = 0; k < NUM_OUT; k++) begin
          q_data.push_back(d[k*DATA_W +: DATA_W]);
          q_idx.push_back(k);
        end
        m_active = 1;
        e_busy   = 1;
      end
    end else begin
      if (st) e_err = 1;
      if (m_finish) begin
        e_done = 1; e_busy = 0; m_active = 0; m_finish = 0;
      end else if (m_gap) begin
        m_gap = 0;
      end else if (rdy) begin
        e_ack  = 1;
        e_data = q_data.pop_front();
        e_idx  = q_idx.pop_front();
        if (q_data.size() == 0) m_finish = 1;
        else if (GAP) m_gap = 1;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("ack", ack, e_ack);
    check_val("busy", busy, e_busy);
    check_val("done", done, e_done);
    check_val("start_err", start_err, e_err);
    check_val("out_data", out_data, e_data);
    check_val("out_idx", out_idx, e_idx);
    if (ack) n_ack_seen++;
  endtask

  task automatic cycle(input bit st, input bit rdy, input logic [DW-1:0] d);
    @(posedge clk);
    check_outputs();
    start = st; ready = rdy; data_in = d;
    model_step(st, rdy, d);
  endtask

  // The reset is asserted between edges. All outputs must clear with no edge.
  task automatic async_reset();
    @(posedge clk);
    check_outputs();
    start = 0; ready = 0;
    #2 rst = 1'b0;
    #1;
    check_val("rst_ack", ack, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", start_err, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_idx", out_idx, 0);
    model_reset();
    @(posedge clk);
    rst = 1'b1;
    model_step(0, 0, data_in);
  endtask

  localparam logic [DW-1:0] D1 = {16'h00BB, 16'h00AA};
  localparam logic [DW-1:0] D2 = {16'h0002, 16'h0001};
  localparam int PASS_GAP = GAP ? 2 * NUM_OUT : NUM_OUT + 1;

  initial begin
    model_reset();
    #1 rst = 1'b0;
    #1;
    check_val("init_busy", busy, 0);
    check_val("init_ack", ack, 0);
    @(posedge clk);
    rst = 1'b1;
    model_step(0, 0, data_in);

    // Basic pass with ready held high.
    cycle(1, 1, D1);
    for (int i = 0; i < 6; i++) cycle(0, 1, '0);
    check_val("basic_err", start_err, 0);

    // Stall: ready stays low for three cycles after start.
    n_ack_seen = 0;
    cycle(1, 0, D1);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0);
    for (int i = 0; i < 6; i++) cycle(0, 1, '0);
    check_val("stall_acks", n_ack_seen, NUM_OUT);

    // Back-to-back: the second start lands in the first IDLE cycle after DONE.
    cycle(1, 1, D1);
    for (int i = 0; i < PASS_GAP; i++) cycle(0, 1, '0);
    cycle(1, 1, D2);
    for (int i = 0; i < 7; i++) cycle(0, 1, '0);
    check_val("b2b_err", start_err, 0);

    // A start while busy, one cycle after the first ack, must be ignored.
    cycle(1, 1, D1);
    cycle(0, 1, '0);
    cycle(1, 1, D2);
    for (int i = 0; i < 7; i++) cycle(0, 1, '0);
    check_val("busy_err", start_err, 1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(3) == 0), ($urandom_range(3) != 0), {$urandom, $urandom});

    // Mid-pass asynchronous reset. Traffic then continues from a clean state.
    cycle(1, 1, {$urandom, $urandom});
    cycle(0, 1, '0);
    async_reset();
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(4) == 0), ($urandom_range(3) != 0), {$urandom, $urandom});
    @(posedge clk);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
